// File: rtl/memory_proc_pkg.sv
// memory_proc: shared types for the memory_proc request/response channel.
//   MemWord : 32-bit data word
//   MemReq  : {is_write, address, wdata}   (65 bits)
//   MemResp : {is_write, err, rdata}       (34 bits)
package memory_proc;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;

  typedef logic [WORD_W-1:0] MemWord;

  typedef struct packed {
    logic              is_write;
    logic [ADDR_W-1:0] address;
    MemWord            wdata;
  } MemReq;

  typedef struct packed {
    logic   is_write;
    logic   err;
    MemWord rdata;
  } MemResp;

endpackage

// File: rtl/memory_resp_fifo.sv
// memory_resp_fifo: show-ahead FIFO with occupancy count.
//   clk, rst_n       : clock, async active-low reset
//   push, push_data  : enqueue (ignored when full and not popping)
//   pop              : dequeue head (ignored when empty)
//   head             : current head; holds last popped value while empty
//   count            : number of valid entries
module memory_resp_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  storage [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [W-1:0]  last;
  logic          empty, full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is the oldest entry; when empty it keeps showing the last value
  // handed out so the output does not wander onto stale storage.
  assign head = empty ? last : storage[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        last   <= storage[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/memory_proc_responder.sv
// memory_proc_responder: terminating memory end of the memory_proc channel.
// Services MemReq from a word array and returns one MemResp per request,
// in order, through a credit-managed show-ahead FIFO (2-cycle min latency).
//   clk, rst_n            : clock, async active-low reset
//   req_data/valid/ready  : MemReq in (valid/ready)
//   resp_data/valid/ready : MemResp out (valid/ready)
// Optional macro MEMORY_PROC_ADDR_CHECK_EN: flag misaligned / out-of-range
// addresses with err=1 (errored writes are dropped, rdata=0). Without it
// the address wraps modulo DEPTH_WORDS and err is 0.
module memory_proc_responder
  import memory_proc::*;
#(
  parameter int DEPTH_WORDS     = 256,
  parameter int ADDR_LSB        = 2,
  parameter int RESP_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [64:0] req_data,
  input  logic        req_valid,
  output logic        req_ready,
  output logic [33:0] resp_data,
  output logic        resp_valid,
  input  logic        resp_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(RESP_FIFO_DEPTH + 1);

  MemReq         req;
  MemWord        mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          accept, req_err;

  logic          s1_valid, s1_is_write, s1_err;
  MemWord        s1_rdata;

  logic [CW-1:0] fifo_count;
  logic [CW:0]   credits_used;

  assign req    = MemReq'(req_data);
  assign idx    = req.address[ADDR_LSB +: AW];
  assign accept = req_valid && req_ready;

`ifdef MEMORY_PROC_ADDR_CHECK_EN
  assign req_err = (|req.address[ADDR_LSB-1:0]) ||
                   ((req.address >> ADDR_LSB) >= ADDR_W'(DEPTH_WORDS));
`else
  logic unused_addr;
  assign unused_addr = ^{req.address};
  assign req_err     = 1'b0;
`endif

  // Credits cover both queued responses and the one in stage 1, so a
  // response always has a FIFO slot. Registers only: no resp_ready path.
  assign credits_used = {1'b0, fifo_count} + (CW+1)'(s1_valid);
  assign req_ready    = credits_used < (CW+1)'(RESP_FIFO_DEPTH);

  // Array is deliberately unreset; writes are blocked while in reset so a
  // stray request cannot corrupt committed contents.
  always_ff @(posedge clk) begin
    if (rst_n && accept && req.is_write && !req_err) mem[idx] <= req.wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_is_write <= 1'b0;
      s1_err      <= 1'b0;
      s1_rdata    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_is_write <= req.is_write;
        s1_err      <= req_err;
        s1_rdata    <= (req.is_write || req_err) ? '0 : mem[idx];
      end
    end
  end

  MemResp s1_resp;
  assign s1_resp = '{is_write: s1_is_write, err: s1_err, rdata: s1_rdata};

  memory_resp_fifo #(
    .W     ($bits(MemResp)),
    .DEPTH (RESP_FIFO_DEPTH),
    .CW    (CW)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s1_valid),
    .push_data (s1_resp),
    .pop       (resp_valid && resp_ready),
    .head      (resp_data),
    .count     (fifo_count)
  );

  assign resp_valid = (fifo_count != '0);

endmodule

// File: tb/tb_memory_proc_responder.sv
module tb_memory_proc_responder;
  import memory_proc::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [64:0] req_data;
  logic        req_valid;
  logic        req_ready;
  logic [33:0] resp_data;
  logic        resp_valid;
  logic        resp_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  memory_proc_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_data   (req_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .resp_data  (resp_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready)
  );

  function automatic logic [31:0] pat(input int k);
    return 32'h1000_0000 + 32'(k) * 32'h11;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Single request then its response; resp_ready held high. ok=0 on timeout.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [33:0] r, output bit ok);
    int n;
    ok = 0; r = '0;
    resp_ready = 1'b1;
    req_data   = {w, a, d};
    req_valid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin req_valid = 1'b0; return; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    if (!resp_valid) return;
    r  = resp_data;
    ok = 1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_data = '0; resp_ready = 1'b0;
    #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
    total++; if (resp_data !== 34'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", resp_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_write_read();
    resp_ready = 1'b0;
    req_data = {1'b1, 32'h10, 32'hDEADBEEF}; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL wr_lat1 got=%b exp=0", resp_valid); end
    @(negedge clk);
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL wr_lat2 got=%b exp=1", resp_valid); end
    total++; if (resp_data !== {1'b1, 1'b0, 32'h0}) begin bad++; $display("FAIL wr_resp got=%h exp=%h", resp_data, {1'b1, 1'b0, 32'h0}); end
    resp_ready = 1'b1;
    tick();
    req_data = {1'b0, 32'h10, 32'h0}; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rd_lat1 got=%b exp=0", resp_valid); end
    @(negedge clk);
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL rd_lat2 got=%b exp=1", resp_valid); end
    total++; if (resp_data !== {1'b0, 1'b0, 32'hDEADBEEF}) begin bad++; $display("FAIL rd_resp got=%h exp=%h", resp_data, {1'b0, 1'b0, 32'hDEADBEEF}); end
    tick();
  endtask

  // 16 writes then 16 reads, one per cycle; response for request c must be
  // visible exactly two iterations later.
  task automatic test_stream();
    logic [33:0] exp;
    int rdy_bad = 0;
    int seen = 0;
    resp_ready = 1'b1;
    for (int c = 0; c < 35; c++) begin
      if (c < 16)      begin req_data = {1'b1, 32'(c * 4), pat(c)}; req_valid = 1'b1; end
      else if (c < 32) begin req_data = {1'b0, 32'((c - 16) * 4), 32'h0}; req_valid = 1'b1; end
      else             req_valid = 1'b0;
      @(negedge clk);
      if (c < 32 && req_ready !== 1'b1) rdy_bad++;
      if (c >= 2 && c < 34) begin
        exp = (c - 2 < 16) ? {1'b1, 1'b0, 32'h0} : {1'b0, 1'b0, pat(c - 18)};
        total++;
        if (resp_valid !== 1'b1 || resp_data !== exp) begin
          bad++; $display("FAIL stream_resp[%0d] got=%b/%h exp=1/%h", c - 2, resp_valid, resp_data, exp);
        end else seen++;
      end
      tick();
    end
    total++; if (rdy_bad != 0) begin bad++; $display("FAIL stream_ready got=%0d low cycles exp=0", rdy_bad); end
    total++; if (seen != 32) begin bad++; $display("FAIL stream_count got=%0d exp=32", seen); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int rc = 0;
    bit take_req;
    resp_ready = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c == 10) begin
        total++;
        if (acc != 4 || req_ready !== 1'b0) begin
          bad++; $display("FAIL bp_full got=acc%0d/rdy%b exp=acc4/rdy0", acc, req_ready);
        end
        resp_ready = 1'b1;
      end
      req_data  = {1'b0, 32'(acc * 4), 32'h0};
      req_valid = (acc < 8);
      @(negedge clk);
      take_req = req_valid && req_ready;
      if (resp_valid && resp_ready) begin
        total++;
        if (resp_data !== {1'b0, 1'b0, pat(rc)}) begin
          bad++; $display("FAIL bp_resp[%0d] got=%h exp=%h", rc, resp_data, {1'b0, 1'b0, pat(rc)});
        end
        rc++;
      end
      tick();
      if (take_req) acc++;
      if (rc == 8) break;
    end
    req_valid = 1'b0;
    total++; if (rc != 8 || acc != 8) begin bad++; $display("FAIL bp_count got=rc%0d/acc%0d exp=8/8", rc, acc); end
  endtask

  task automatic test_addr_range();
    logic [33:0] r;
    bit ok;
    xact(1'b1, 32'h400, 32'h1234, r, ok);
    total++;
`ifdef MEMORY_PROC_ADDR_CHECK_EN
    if (!ok || r !== {1'b1, 1'b1, 32'h0}) begin bad++; $display("FAIL range_wr got=%h ok=%0d exp=%h", r, ok, {1'b1, 1'b1, 32'h0}); end
`else
    if (!ok || r !== {1'b1, 1'b0, 32'h0}) begin bad++; $display("FAIL range_wr got=%h ok=%0d exp=%h", r, ok, {1'b1, 1'b0, 32'h0}); end
`endif
    xact(1'b0, 32'h0, 32'h0, r, ok);
    total++;
`ifdef MEMORY_PROC_ADDR_CHECK_EN
    if (!ok || r !== {1'b0, 1'b0, pat(0)}) begin bad++; $display("FAIL range_rd got=%h ok=%0d exp=%h", r, ok, {1'b0, 1'b0, pat(0)}); end
`else
    if (!ok || r !== {1'b0, 1'b0, 32'h1234}) begin bad++; $display("FAIL range_rd got=%h ok=%0d exp=%h", r, ok, {1'b0, 1'b0, 32'h1234}); end
`endif
  endtask

  task automatic test_misaligned();
    logic [33:0] r;
    bit ok;
    xact(1'b0, 32'h13, 32'h0, r, ok);
    total++;
`ifdef MEMORY_PROC_ADDR_CHECK_EN
    if (!ok || r !== {1'b0, 1'b1, 32'h0}) begin bad++; $display("FAIL misalign got=%h ok=%0d exp=%h", r, ok, {1'b0, 1'b1, 32'h0}); end
`else
    if (!ok || r !== {1'b0, 1'b0, pat(4)}) begin bad++; $display("FAIL misalign got=%h ok=%0d exp=%h", r, ok, {1'b0, 1'b0, pat(4)}); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [33:0] r;
    bit ok;
    resp_ready = 1'b0;
    req_data = {1'b0, 32'h8, 32'h0}; req_valid = 1'b1;
    tick();
    req_data = {1'b0, 32'hC, 32'h0};
    tick();
    req_valid = 1'b0;
    tick(); tick();
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL rstmid_queued got=%b exp=1", resp_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", resp_valid); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_after got=rdy%b/vld%b exp=1/0", req_ready, resp_valid); end
    xact(1'b0, 32'h20, 32'h0, r, ok);
    total++; if (!ok || r !== {1'b0, 1'b0, pat(8)}) begin bad++; $display("FAIL rstmid_rd8 got=%h ok=%0d exp=%h", r, ok, {1'b0, 1'b0, pat(8)}); end
    xact(1'b0, 32'h8, 32'h0, r, ok);
    total++; if (!ok || r !== {1'b0, 1'b0, pat(2)}) begin bad++; $display("FAIL rstmid_rd2 got=%h ok=%0d exp=%h", r, ok, {1'b0, 1'b0, pat(2)}); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_stream();
    test_backpressure();
    test_addr_range();
    test_misaligned();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
